// File: rtl/mul_wide_arb.sv
// mul_wide_arb: round-robin arbiter that shares one pipelined wide multiplier among N requesters.
// Each issued operation carries {valid, id, tag} through the multiplier sideband. Returning
// products land in a first-word-fall-through response FIFO. Issue is credit-controlled, so a
// product always has a FIFO slot waiting for it.
// Optional build macro: MUL_WIDE_ARB_STATS_EN adds the stat_issued / stat_stall counters.

module mul_wide_arb #(
  parameter int unsigned W     = 384,
  parameter int unsigned N     = 4,
  parameter int unsigned LAT   = 16,
  parameter int unsigned TW    = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned M     = 1 + $clog2(N) + TW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*W-1:0]         req_in0,
  input  logic [N*W-1:0]         req_in1,
  input  logic [N*TW-1:0]        req_tag,
  output logic [W-1:0]           mul_in0,
  output logic [W-1:0]           mul_in1,
  output logic [M-1:0]           mul_m_i,
  input  logic [M-1:0]           mul_m_o,
  input  logic [2*W-1:0]         mul_out0,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [TW-1:0]          rsp_tag,
  output logic [2*W-1:0]         rsp_data
`ifdef MUL_WIDE_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned DCW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int unsigned EW  = IW + TW + 2 * W;

  typedef enum logic {StDrain, StRun} state_e;

  state_e          state;
  logic [DCW-1:0]  drain_cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic            found;
  logic [CW-1:0]   credits;
  logic            issue;
  logic            pop;
  logic            push;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic [EW-1:0]   head;

  // Round-robin search for the first valid requester at or after rr_ptr.
  always_comb begin
    logic [IW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(rr_ptr) + k) % N);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant is combinational; it is withheld while draining or out of credits.
  always_comb begin
    req_ready = '0;
    issue     = (state == StRun) && (credits != '0) && found;
    if (issue) req_ready[winner] = 1'b1;
  end

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // Sideband results seen while draining are stale pipeline contents and are dropped.
  assign push      = (state == StRun) && mul_m_o[M-1];
  assign fifo_full = (count == CW'(DEPTH));
  assign head      = mem[rd_ptr];

  // Post-reset drain: hold off issue for LAT+1 cycles so the unreset multiplier empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StDrain;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        StDrain: begin
          if (drain_cnt == DCW'(LAT)) state <= StRun;
          else drain_cnt <= drain_cnt + DCW'(1);
        end
        StRun:   state <= StRun;
        default: state <= StDrain;
      endcase
    end
  end

  // Issue registers feeding the multiplier, and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_in0 <= '0;
      mul_in1 <= '0;
      mul_m_i <= '0;
      rr_ptr  <= '0;
    end else begin
      mul_m_i <= '0;
      if (issue) begin
        mul_in0 <= req_in0[32'(winner) * W +: W];
        mul_in1 <= req_in1[32'(winner) * W +: W];
        mul_m_i <= {1'b1, winner, req_tag[32'(winner) * TW +: TW]};
        rr_ptr  <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
      end
    end
  end

  // Credits track free FIFO slots minus operations still in the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(DEPTH);
    end else begin
      unique case ({issue, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !fifo_full) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      unique case ({push && !fifo_full, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because reads are gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (push && !fifo_full) mem[wr_ptr] <= {mul_m_o[TW +: IW], mul_m_o[TW-1:0], mul_out0};
  end

  assign rsp_id   = rsp_valid ? head[EW-1 -: IW] : '0;
  assign rsp_tag  = rsp_valid ? head[2*W +: TW] : '0;
  assign rsp_data = rsp_valid ? head[2*W-1:0] : '0;

  // The credit scheme must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);

`ifdef MUL_WIDE_ARB_STATS_EN
  // Saturating issue and credit-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
      if ((state == StRun) && (|req_valid) && (credits == '0) && (stat_stall != '1))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_wide_arb.sv
// Directed bench for mul_wide_arb with a behavioural LAT-stage multiplier model.

module tb_mul_wide_arb;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 2;
  localparam int unsigned M     = 1 + IW + TW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_in0;
  logic [N*W-1:0]  req_in1;
  logic [N*TW-1:0] req_tag;
  logic [W-1:0]    mul_in0;
  logic [W-1:0]    mul_in1;
  logic [M-1:0]    mul_m_i;
  logic [M-1:0]    mul_m_o;
  logic [2*W-1:0]  mul_out0;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [2*W-1:0]  rsp_data;
`ifdef MUL_WIDE_ARB_STATS_EN
  logic [31:0]     stat_issued;
  logic [31:0]     stat_stall;
`endif

  mul_wide_arb #(
    .W(W), .N(N), .LAT(LAT), .TW(TW), .DEPTH(DEPTH), .M(M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .req_tag   (req_tag),
    .mul_in0   (mul_in0),
    .mul_in1   (mul_in1),
    .mul_m_i   (mul_m_i),
    .mul_m_o   (mul_m_o),
    .mul_out0  (mul_out0),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data)
`ifdef MUL_WIDE_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: LAT register stages, never reset.
  logic [M-1:0]   pm [LAT];
  logic [2*W-1:0] pp [LAT];
  always @(posedge clk) begin
    pm[0] <= mul_m_i;
    pp[0] <= 64'(mul_in0) * 64'(mul_in1);
    for (int i = 1; i < LAT; i++) begin
      pm[i] <= pm[i-1];
      pp[i] <= pp[i-1];
    end
  end
  assign mul_m_o  = pm[LAT-1];
  assign mul_out0 = pp[LAT-1];

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] data;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_popped = 0;
  int seq      = 0;
  int base;
  int base_pop;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_in0[i*W +: W]   = 32'h9E37_79B9 * 32'(seq) + 32'(i) + 32'd1;
      req_in1[i*W +: W]   = 32'hFFFF_FFFF - 32'(seq * 7 + i);
      req_tag[i*TW +: TW] = 8'(seq * 4 + i);
    end
    seq++;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    set_ops();
    #1;
  endtask

  // Record handshakes, score pops against the expected queue, then advance one cycle.
  task automatic step();
    exp_t e;
    check("grant_onehot0", 128'($onehot0(req_ready)), 128'(1));
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = IW'(i);
        e.tag  = req_tag[i*TW +: TW];
        e.data = 64'(req_in0[i*W +: W]) * 64'(req_in1[i*W +: W]);
        q.push_back(e);
        n_issued++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_popped++;
      if (q.size() == 0) begin
        check("rsp_unexpected", 128'(rsp_valid), 128'(0));
      end else begin
        e = q.pop_front();
        check("rsp_id", 128'(rsp_id), 128'(e.id));
        check("rsp_tag", 128'(rsp_tag), 128'(e.tag));
        check("rsp_data", 128'(rsp_data), 128'(e.data));
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_in0   = '0;
    req_in1   = '0;
    req_tag   = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_mul_m_i", 128'(mul_m_i), 128'(0));
    check("rst_mul_in0", 128'(mul_in0), 128'(0));
    check("rst_mul_in1", 128'(mul_in1), 128'(0));
    check("rst_rsp_id", 128'(rsp_id), 128'(0));
    check("rst_rsp_tag", 128'(rsp_tag), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
`ifdef MUL_WIDE_ARB_STATS_EN
    check("rst_stat_issued", 128'(stat_issued), 128'(0));
    check("rst_stat_stall", 128'(stat_stall), 128'(0));
`endif
    rst = 1'b0;

    // Single request from requester 2 through the drain window.
    req_valid          = 4'b0100;
    req_in0[2*W +: W]  = 32'd3;
    req_in1[2*W +: W]  = 32'd7;
    req_tag[2*TW +: TW] = 8'h5A;
    #1;
    for (int k = 0; k < LAT + 1; k++) begin
      check("drain_req_ready", 128'(req_ready), 128'(0));
      step();
    end
    #1;
    check("first_grant", 128'(req_ready), 128'(4'b0100));
    step();
    req_valid = '0;
    #1;
    check("issue_m_i", 128'(mul_m_i), 128'({1'b1, 2'd2, 8'h5A}));
    check("issue_in0", 128'(mul_in0), 128'(3));
    check("issue_in1", 128'(mul_in1), 128'(7));
    repeat (LAT) step();
    check("rsp_not_early", 128'(rsp_valid), 128'(0));
    step();
    check("rsp_on_time", 128'(rsp_valid), 128'(1));
    check("single_data", 128'(rsp_data), 128'(21));
    check("single_id", 128'(rsp_id), 128'(2));
    check("single_tag", 128'(rsp_tag), 128'(8'h5A));
    rsp_ready = 1'b1;
    #1;
    step();
    check("single_popped", 128'(rsp_valid), 128'(0));
`ifdef MUL_WIDE_ARB_STATS_EN
    check("stat_issued_one", 128'(stat_issued), 128'(1));
`endif

    // All requesters valid: grants rotate starting after requester 2.
    base_pop = n_popped;
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1);
      g = 4'b0001 << ((3 + k) % 4);
      check("rotate_grant", 128'(req_ready), 128'(g));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(4'b0000, 1'b1);
      step();
    end
    check("rotate_resp_count", 128'(n_popped - base_pop), 128'(8));
    check("rotate_queue_empty", 128'(q.size()), 128'(0));

    // Backpressure: exactly DEPTH issues, then stall.
    base = n_issued;
    for (int k = 0; k < 16; k++) begin
      drive(4'b1111, 1'b0);
      step();
    end
    check("bp_issue_count", 128'(n_issued - base), 128'(DEPTH));
    drive(4'b1111, 1'b0);
    check("bp_stalled", 128'(req_ready), 128'(0));
    step();
    // One-cycle release frees exactly one slot.
    drive(4'b1111, 1'b1);
    check("release_same_cycle", 128'(req_ready), 128'(0));
    step();
    drive(4'b1111, 1'b0);
    check("release_one_issue", 128'($countones(req_ready)), 128'(1));
    step();
    drive(4'b1111, 1'b0);
    check("release_then_stall", 128'(req_ready), 128'(0));
    step();
    // Continuous pop at credits=1: issue and pop coincide every cycle.
    drive(4'b1111, 1'b1);
    check("credit_zero_pop", 128'(req_ready), 128'(0));
    step();
    for (int k = 0; k < 10; k++) begin
      drive(4'b1111, 1'b1);
      check("credit1_issue", 128'($countones(req_ready)), 128'(1));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(4'b0000, 1'b1);
      step();
    end
    check("bp_queue_empty", 128'(q.size()), 128'(0));
    check("bp_no_loss", 128'(n_popped), 128'(n_issued));
    check("bp_idle_valid", 128'(rsp_valid), 128'(0));

    // Reset with operations in flight and buffered.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b0);
      step();
    end
    check("pre_rst_buffered", 128'(rsp_valid), 128'(1));
    rst = 1'b1;
    drive(4'b1111, 1'b0);
    step();
    rst = 1'b0;
    q.delete();
    check("post_rst_rsp_valid", 128'(rsp_valid), 128'(0));
`ifdef MUL_WIDE_ARB_STATS_EN
    check("post_rst_stat_issued", 128'(stat_issued), 128'(0));
    check("post_rst_stat_stall", 128'(stat_stall), 128'(0));
`endif
    for (int k = 0; k < LAT + 1; k++) begin
      drive(4'b1111, 1'b0);
      check("drain2_req_ready", 128'(req_ready), 128'(0));
      check("drain2_no_stale", 128'(rsp_valid), 128'(0));
      step();
    end
    base     = n_issued;
    base_pop = n_popped;
    drive(4'b1111, 1'b0);
    check("post_rst_grant", 128'(req_ready), 128'(4'b0001));
    step();
    for (int k = 0; k < 15; k++) begin
      drive(4'b1111, 1'b0);
      step();
    end
    check("post_rst_credits", 128'(n_issued - base), 128'(DEPTH));
    for (int k = 0; k < 20; k++) begin
      drive(4'b0000, 1'b1);
      step();
    end
    check("post_rst_resp_count", 128'(n_popped - base_pop), 128'(DEPTH));
    check("post_rst_queue_empty", 128'(q.size()), 128'(0));
`ifdef MUL_WIDE_ARB_STATS_EN
    check("stat_issued_post", 128'(stat_issued), 128'(DEPTH));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_wide_arb.md
# mul_wide_arb

Round-robin arbiter that shares one fully pipelined, non-stallable wide multiplier among N requesters. It tags each issued operation through the multiplier's sideband (`m_i`/`m_o`) and buffers returning products in a response FIFO. Issue is credit-controlled, so a product is never dropped when the consumer backpressures. It sits between the MSM bucket/point-arithmetic units and a single `mul_wide` instance.

## Interface
Parameters:
- `W`, 384: operand width; product width is 2W.
- `N`, 4: number of requesters, ≥2.
- `LAT`, 16: cycles from multiplier input to `out0`/`m_o`; must equal the instantiated multiplier's latency.
- `TW`, 8: requester tag width.
- `DEPTH`, 32: response FIFO depth and initial credit count; must be ≥ LAT+2.
- `M`, 1+$clog2(N)+TW: sideband width, packed as {valid, id, tag}.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous and active-high; one clock domain.
- `req_valid` in N: per-requester request valid.
- `req_ready` out N: per-requester grant; at most one bit high.
- `req_in0` in N·W: operand A, requester i at slice [i·W +: W].
- `req_in1` in N·W: operand B, same packing as `req_in0`.
- `req_tag` in N·TW: request tag, requester i at slice [i·TW +: TW].
- `mul_in0` out W: multiplier operand A, registered.
- `mul_in1` out W: multiplier operand B, registered.
- `mul_m_i` out M: multiplier sideband in, registered.
- `mul_m_o` in M: multiplier sideband out.
- `mul_out0` in 2W: multiplier product.
- `rsp_valid` out 1: response valid (FIFO head).
- `rsp_ready` in 1: response accept.
- `rsp_id` out $clog2(N): index of the originating requester.
- `rsp_tag` out TW: tag of the originating request.
- `rsp_data` out 2W: product.

## Operation
- States:
  - DRAIN: entered on `rst`. A counter runs LAT+1 cycles. `req_ready`=0. Any `mul_m_o` that arrives is discarded, because the multiplier pipeline is not reset and may still carry stale valid bits.
  - RUN: entered when the counter expires. Normal operation.
- Arbitration, in RUN with credits>0:
  - Winner is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo N.
  - `req_ready[winner]`=1. It is combinational from `req_valid`, `rr_ptr` and the credit count.
  - On handshake, `rr_ptr` ← winner+1 mod N. With no handshake, `rr_ptr` holds.
- Issue:
  - On handshake at cycle t, registers load `mul_in0`/`mul_in1` from the winner's slices and `mul_m_i`={1, winner, tag}.
  - With no handshake, the `mul_m_i` valid bit is 0. Operands hold their previous value, which is don't-care.
- Return:
  - When `mul_m_o` valid=1 in RUN, {id, tag, `mul_out0`} is pushed into the FIFO.
  - The FIFO is first-word-fall-through, so order equals issue order.
- Credits:
  - Reset value is DEPTH.
  - −1 on issue, +1 on pop (`rsp_valid`&`rsp_ready`). Simultaneous issue and pop: unchanged.
  - credits=0 forces `req_ready`=0.
  - Credits cover in-flight operations plus FIFO occupancy, so a push into a full FIFO cannot occur. Hitting that case fires an assertion in simulation.
- Reset mid-operation: in-flight and buffered results are lost, and requesters must reissue. `rsp_valid` drops the cycle after `rst` is sampled.

## Timing
- Reset values:
  - `req_ready`=0.
  - `rsp_valid`=0.
  - `mul_m_i`=0.
  - `mul_in0`/`mul_in1`=0.
  - `rsp_id`/`rsp_tag`/`rsp_data`=0.
  - credits=DEPTH, `rr_ptr`=0, state DRAIN.
- First possible `req_ready`: LAT+2 cycles after `rst` deasserts.
- Handshake at t:
  - `mul_m_i` valid at t+1.
  - `mul_m_o` valid at t+1+LAT.
  - `rsp_valid` at t+2+LAT, when the FIFO was empty.
- Throughput: one issue per cycle sustained while credits>0 and the consumer keeps `rsp_ready`=1.
- FIFO full and empty coincide with credits=0 and credits=DEPTH respectively, once the pipeline has drained.

## Configuration
- `MUL_WIDE_ARB_STATS_EN` defined:
  - Adds outputs `stat_issued` (32b, increments on each issue).
  - Adds `stat_stall` (32b, increments each RUN cycle with any `req_valid` set and credits=0).
  - Both counters saturate at 2^32−1 and clear on `rst`.
- Undefined: the counters and these ports do not exist.

## Test plan
- Reset then single request: requester 2, tag 0x5A, in0=3, in1=7, handshake at t → `mul_m_i`={1,2,0x5A} at t+1; `rsp_valid` at t+2+LAT with `rsp_data`=21, `rsp_id`=2, `rsp_tag`=0x5A.
- All N requesters valid continuously, `rsp_ready`=1 → grants rotate 0,1,2,3,0,…; one issue every cycle; responses arrive in the same order.
- `rsp_ready`=0 with requests always valid → exactly DEPTH issues, then `req_ready`=0. Raising `rsp_ready` for one cycle allows exactly one more issue; no product is lost or reordered.
- Simultaneous pop and issue at credits=1 → credits stay 1, and issue continues every cycle.
- `rst` asserted with 10 ops in flight and 5 buffered → `rsp_valid`=0 next cycle. Stale `mul_m_o` valids during DRAIN are not pushed. `req_ready` stays 0 for LAT+1 cycles, then normal operation resumes with credits=DEPTH.
- With `MUL_WIDE_ARB_STATS_EN`: 100 issues and 12 credit-stall cycles → `stat_issued`=100, `stat_stall`=12; both are 0 after `rst`.
